gx_fifo_fetch: RTL
==================

GX_FIFO_FETCH -- requirements
Module: gx_fifo_fetch

Interface
REQ-001 SHALL have parameter BUF_BEATS, default 16, depth of the 128-bit beat buffer (power of two, >=4).
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-003 SHALL have enable in 1 (fetch allowed), fifo_base in 32 (ring start), fifo_end in 32 (exclusive ring limit) and fifo_wrptr in 32 (CPU write pointer); all three pointers are 32-byte aligned and come from the command processor (CP) registers.
REQ-004 SHALL have rdptr_load in 1 (load read pointer), rdptr_in in 32 (value to load) and rdptr out 32 (current read pointer).
REQ-005 SHALL have an error out 1, a sticky AXI read error.
REQ-006 SHALL have AXI read-address master ports araddrm_a out 32, arburstm_a out 2, arlenm_a out 4, arsizem_a out 3, arvalidm_a out 1 and arreadym_a in 1.
REQ-007 SHALL have AXI read-data master ports rdatam_a in 128, rrespm_a in 2, rlastm_a in 1, rvalidm_a in 1 and rreadym_a out 1.
REQ-008 SHALL have a CP word stream: cmd_data out 32, cmd_valid out 1 and cmd_ready in 1.

Function
REQ-009 SHALL issue 32-byte granules only: arlenm_a=1 (2 beats), arsizem_a=3'b100, arburstm_a=2'b01 (INCR), araddrm_a=rdptr.
REQ-010 SHALL allow at most one outstanding burst.
REQ-011 SHALL use FSM states IDLE, ADDR, DATA, HALT.
REQ-012 IDLE->ADDR SHALL occur when all hold: enable=1, rdptr!=fifo_wrptr, error=0, no rdptr_load this cycle, and buffer free slots >=2.
REQ-013 In ADDR, arvalidm_a SHALL be 1 and address/len SHALL hold stable until arreadym_a; the handshake cycle moves to DATA.
REQ-014 In DATA, rreadym_a SHALL be 1 and each rvalidm_a beat SHALL be written to the buffer; rreadym_a SHALL be 0 in all other states.
REQ-015 On the beat with rlastm_a=1 and rrespm_a=OKAY (both beats OKAY): rdptr <= (rdptr+32 >= fifo_end) ? fifo_base : rdptr+32; state -> IDLE.
REQ-016 Any beat with rrespm_a!=0 SHALL be discarded, set error=1, leave rdptr unchanged, and move to HALT after rlast (remaining beats drained and discarded).
REQ-017 HALT SHALL be left only by reset.
REQ-018 Width conversion: each beat SHALL emit 4 words in order rdata[31:0], [63:32], [95:64], [127:96]; no byte swapping.
REQ-019 cmd_valid SHALL assert no earlier than the cycle after the beat is written (1-cycle minimum latency).
REQ-020 cmd_data/cmd_valid SHALL hold stable while cmd_valid=1 and cmd_ready=0.
REQ-021 Full sustained throughput SHALL be 1 word/cycle when cmd_ready=1.
REQ-022 Free-slot check SHALL count buffered beats plus the 2 reserved for the in-flight burst; the buffer SHALL never overflow.
REQ-023 enable deassert mid-burst SHALL finish the current burst normally (data kept, rdptr advanced); no new burst is issued.
REQ-024 rdptr_load SHALL be honoured only in IDLE: rdptr<=rdptr_in and buffer/word counter are flushed in the same cycle; in other states it SHALL be ignored.
REQ-025 Empty (rdptr==fifo_wrptr) SHALL issue nothing; wrptr may move on any cycle and is sampled in IDLE only.
REQ-026 Wrap SHALL be exact: rdptr==fifo_end-32 advances to fifo_base.

Reset
REQ-027 Reset SHALL set state=IDLE, rdptr=0, error=0, arvalidm_a=0, rreadym_a=0, cmd_valid=0, cmd_data=0, buffer empty and word index 0.
REQ-028 Reset mid-burst SHALL abandon the burst with no further AXI handshakes; the interconnect is reset together with this block.

Structure
REQ-029 Package flipper_pkg SHALL hold the FSM state enum, AXI_BURST_INCR, AXI_SIZE_16B, GRANULE_BYTES=32 and the AXI_RESP_OKAY constants.
REQ-030 The beat buffer SHALL be a separate sub-module gx_sync_fifo (parameterised width/depth, synchronous, registered status, sync active-high reset).
REQ-031 Width conversion and the FSM SHALL live in gx_fifo_fetch; the 128-bit buffer output is muxed by a 2-bit word index.

Verification
REQ-032 base=0x1000, end=0x1100, rdptr=0x1000, wrptr=0x1040, enable=1 -> exactly 2 bursts at 0x1000 and 0x1020, 16 words out in order, rdptr=0x1040, then idle.
REQ-033 rdptr=0x10E0, wrptr=0x1020 -> bursts at 0x10E0, 0x1000; rdptr ends 0x1020.
REQ-034 cmd_ready=0 throughout, large ring -> stops after BUF_BEATS/2 bursts, arvalidm_a stays 0, no beat is lost after cmd_ready rises.
REQ-035 Second beat of a burst returns SLVERR -> error=1, no words emitted from that burst, rdptr unchanged, no further arvalidm_a until reset.
REQ-036 enable drops on the cycle after the AR handshake -> burst completes, 8 words emitted, rdptr += 32, no new AR.
REQ-037 arreadym_a held low for 10 cycles with random rvalid/cmd_ready gaps -> araddrm_a stable, output sequence matches the memory model word-for-word.

Source files
------------

// File: rtl/flipper_pkg.sv
// Shared types and AXI constants for the CP command-FIFO fetch path.
package flipper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_HALT
    } fetch_state_e;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]  AXI_SIZE_16B   = 3'b100;
    localparam logic [3:0]  AXI_LEN_2BEAT  = 4'd1;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [31:0] GRANULE_BYTES  = 32'd32;

    // Advance a ring pointer by one granule, wrapping at the exclusive limit.
    function automatic logic [31:0] ring_next(
        input logic [31:0] ptr,
        input logic [31:0] base,
        input logic [31:0] lim
    );
        logic [31:0] sum;
        sum = ptr + GRANULE_BYTES;
        return (sum >= lim) ? base : sum;
    endfunction

endpackage

// File: rtl/gx_sync_fifo.sv
// Synchronous beat buffer with registered status.
// Writes stay invisible to the reader until committed; rollback drops them.
module gx_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     commit,
    input  logic                     rollback,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   used
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, cm_ptr, rd_ptr;
    logic [AW:0] wr_nxt, cm_nxt, rd_nxt;

    always_comb begin
        wr_nxt = wr_ptr;
        cm_nxt = cm_ptr;
        rd_nxt = rd_ptr;
        if (wr_en) begin
            wr_nxt = wr_ptr + 1'b1;
        end
        if (commit) begin
            cm_nxt = wr_nxt;
        end
        if (rollback) begin
            wr_nxt = cm_ptr;
        end
        if (rd_en && !empty) begin
            rd_nxt = rd_ptr + 1'b1;
        end
        if (flush) begin
            wr_nxt = '0;
            cm_nxt = '0;
            rd_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            cm_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            used   <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            cm_ptr <= cm_nxt;
            rd_ptr <= rd_nxt;
            empty  <= (cm_nxt == rd_nxt);
            used   <= wr_nxt - rd_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/gx_fifo_fetch.sv
// CP command-FIFO fetcher: reads 32-byte granules over AXI from a ring
// and streams them to the command processor one 32-bit word at a time.
module gx_fifo_fetch
    import flipper_pkg::*;
#(
    parameter int BUF_BEATS = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [31:0]  fifo_base,
    input  logic [31:0]  fifo_end,
    input  logic [31:0]  fifo_wrptr,
    input  logic         rdptr_load,
    input  logic [31:0]  rdptr_in,
    output logic [31:0]  rdptr,
    output logic         error,
    output logic [31:0]  araddrm_a,
    output logic [1:0]   arburstm_a,
    output logic [3:0]   arlenm_a,
    output logic [2:0]   arsizem_a,
    output logic         arvalidm_a,
    input  logic         arreadym_a,
    input  logic [127:0] rdatam_a,
    input  logic [1:0]   rrespm_a,
    input  logic         rlastm_a,
    input  logic         rvalidm_a,
    output logic         rreadym_a,
    output logic [31:0]  cmd_data,
    output logic         cmd_valid,
    input  logic         cmd_ready
);

    localparam int AW = $clog2(BUF_BEATS);
    localparam int UW = AW + 1;
    localparam logic [AW:0] FILL_LIMIT = UW'(BUF_BEATS - 2);

    fetch_state_e state, state_nxt;

    logic          fifo_wr, fifo_commit, fifo_rollback;
    logic          fifo_rd, fifo_flush, fifo_empty;
    logic [127:0]  beat;
    logic [AW:0]   used;
    logic [1:0]    widx;
    logic          beat_ok, load_now, out_adv, can_issue;

    assign araddrm_a  = rdptr;
    assign arburstm_a = AXI_BURST_INCR;
    assign arlenm_a   = AXI_LEN_2BEAT;
    assign arsizem_a  = AXI_SIZE_16B;

    // A burst is usable only if every beat so far came back OKAY.
    assign beat_ok   = (rrespm_a == AXI_RESP_OKAY) && !error;
    assign load_now  = rdptr_load && (state == ST_IDLE);
    assign can_issue = enable && (rdptr != fifo_wrptr) && !error
                     && !rdptr_load && (used <= FILL_LIMIT);

    always_comb begin
        state_nxt     = state;
        arvalidm_a    = 1'b0;
        rreadym_a     = 1'b0;
        fifo_wr       = 1'b0;
        fifo_commit   = 1'b0;
        fifo_rollback = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (can_issue) begin
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                arvalidm_a = 1'b1;
                if (arreadym_a) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                rreadym_a = 1'b1;
                if (rvalidm_a) begin
                    fifo_wr = beat_ok;
                    if (rlastm_a) begin
                        if (beat_ok) begin
                            fifo_commit = 1'b1;
                            state_nxt   = ST_IDLE;
                        end else begin
                            fifo_rollback = 1'b1;
                            state_nxt     = ST_HALT;
                        end
                    end
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            rdptr <= '0;
            error <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_now) begin
                rdptr <= rdptr_in;
            end else if (fifo_commit) begin
                rdptr <= ring_next(rdptr, fifo_base, fifo_end);
            end
            if (state == ST_DATA && rvalidm_a
                && rrespm_a != AXI_RESP_OKAY) begin
                error <= 1'b1;
            end
        end
    end

    gx_sync_fifo #(
        .WIDTH (128),
        .DEPTH (BUF_BEATS)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .flush    (fifo_flush),
        .wr_en    (fifo_wr),
        .wr_data  (rdatam_a),
        .commit   (fifo_commit),
        .rollback (fifo_rollback),
        .rd_en    (fifo_rd),
        .rd_data  (beat),
        .empty    (fifo_empty),
        .used     (used)
    );

    // Output register: a new word loads whenever the slot is free or taken.
    assign fifo_flush = load_now;
    assign out_adv    = !fifo_empty && (!cmd_valid || cmd_ready);
    assign fifo_rd    = out_adv && (widx == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            widx      <= '0;
        end else if (load_now) begin
            cmd_valid <= 1'b0;
            widx      <= '0;
        end else if (out_adv) begin
            cmd_data  <= beat[{widx, 5'b00000} +: 32];
            cmd_valid <= 1'b1;
            widx      <= widx + 2'd1;
        end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
        end
    end

endmodule
